exe_mem_pipe: RTL and testbench
===============================

EXE_MEM_PIPE -- requirements
Module: exe_mem_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, ALU result and store-data width.
REQ-002 SHALL have parameter REG_W, default 4, destination register index width.
REQ-003 SHALL have parameter NOP_REG, default all ones, destination index meaning "no write".
REQ-004 SHALL have parameter WB_IDLE, default 1'b1, controlwb value meaning "no writeback".
REQ-005 clk  in  1  single clock; all state updates on the falling edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 stall_in  in  1  hold all stage contents this cycle.
REQ-008 flush_in  in  1  replace stage contents with a bubble this cycle.
REQ-009 valid_in  in  1  EXE stage holds a real instruction.
REQ-010 controlmem_in  in  2  memory op: 00 none, 01 read, 10 write, 11 illegal.
REQ-011 controlwb_in  in  1  writeback control.
REQ-012 alu_in, wdata_in  in  DATA_W each  ALU result and store data.
REQ-013 wreg_in  in  REG_W  destination register index.
REQ-014 valid_out, memread_out, memwrite_out, controlwb_out  out  1 each  registered controls.
REQ-015 alu_out, wdata_out  out  DATA_W; wreg_out  out  REG_W  registered data.
REQ-016 illegal_op_out  out  1  sticky flag for an illegal memory op.

Function
REQ-017 Normal load (no stall, no flush) SHALL capture all inputs in one falling edge; latency is exactly 1 cycle.
REQ-018 Decode SHALL be 01 -> read=1/write=0, 10 -> write=1/read=0, 00 or 11 -> both 0; read and write are never 1 together.
REQ-019 A bubble SHALL be: valid 0, read 0, write 0, controlwb WB_IDLE, wreg NOP_REG, alu 0, wdata 0.
REQ-020 valid_in=0 with no stall or flush SHALL load a bubble; other inputs are ignored.
REQ-021 stall_in=1 SHALL hold every output unchanged, including illegal_op_out.
REQ-022 flush_in=1 SHALL load a bubble; flush overrides stall when both are asserted.
REQ-023 A loaded controlmem_in=11 with valid_in=1 SHALL set illegal_op_out at that edge; it stays set until reset.
REQ-024 A loaded illegal op SHALL otherwise propagate as a valid op with read=0 and write=0; alu, wdata, wreg and controlwb are captured normally.

Reset
REQ-025 rst=1 SHALL immediately force the bubble values of REQ-019 and illegal_op_out=0, independent of clk.
REQ-026 Reset asserted mid-stall or mid-flush SHALL win; the first falling edge after rst deasserts SHALL apply normal rules.

Configuration
REQ-027 With EXE_MEM_PERF_CNT_EN defined, SHALL add outputs stall_cnt_out and bubble_cnt_out, 32 bits each.
REQ-028 stall_cnt_out SHALL count edges with stall_in=1 and flush_in=0.
REQ-029 bubble_cnt_out SHALL count edges that load a bubble by flush or by valid_in=0.
REQ-030 Both counters SHALL wrap modulo 2^32 and reset to 0.
REQ-031 Without EXE_MEM_PERF_CNT_EN, the counter ports and their logic SHALL not exist; all other behaviour is identical.

Structure
REQ-032 The shared package SHALL hold the 2-bit mem-op encodings (MEM_NONE, MEM_READ, MEM_WRITE, MEM_ILLEGAL) and the default NOP_REG/WB_IDLE constants.
REQ-033 One sub-module, exe_mem_perf_cnt, SHALL implement the counters; it is instantiated only under EXE_MEM_PERF_CNT_EN.

Verification
REQ-034 Reset: assert rst between edges -> outputs go to bubble and wreg_out=4'hF at once, with no clock edge needed.
REQ-035 Load: valid 1, op 10, alu 16'h1234, wdata 16'hBEEF, wreg 3 -> next edge: write=1, read=0, alu=1234, wdata=BEEF, wreg=3, valid=1.
REQ-036 Stall: load op 01/alu 16'h00AA, then stall 3 edges with new inputs -> outputs stay 00AA/read=1; stall_cnt=3 with the macro defined.
REQ-037 Flush and stall together on one edge -> bubble loaded; bubble_cnt increments by 1 and stall_cnt is unchanged.
REQ-038 Illegal op: op 11, valid 1 -> read=0, write=0, valid=1, illegal_op_out=1; a following op 00 leaves illegal_op_out=1 until rst.
REQ-039 Parameters: DATA_W=32, REG_W=5 -> alu 32'hDEADBEEF passes intact; bubble wreg_out=5'h1F.

Source files
------------

// File: rtl/exe_mem_pipe_pkg.sv
// exe_mem_pipe_pkg
//   Shared definitions for the EXE/MEM pipeline register slice:
//   - 2-bit memory-op encodings carried on controlmem_in
//   - default "no write" destination index and "no writeback" control value
//   - mem-op decode helper returning {read, write}
package exe_mem_pipe_pkg;

    localparam logic [1:0] MEM_NONE    = 2'b00;
    localparam logic [1:0] MEM_READ    = 2'b01;
    localparam logic [1:0] MEM_WRITE   = 2'b10;
    localparam logic [1:0] MEM_ILLEGAL = 2'b11;

    // Wide enough for any realistic register index; sliced to REG_W at use.
    localparam logic [31:0] NOP_REG_DEF = 32'hFFFF_FFFF;
    localparam logic        WB_IDLE_DEF = 1'b1;

    // Returns {read, write}. Only the two legal access encodings produce a
    // strobe, so read and write can never be high together.
    function automatic logic [1:0] decode_mem(input logic [1:0] op);
        logic [1:0] rw;
        rw = 2'b00;
        case (op)
            MEM_READ:  rw = 2'b10;
            MEM_WRITE: rw = 2'b01;
            default:   rw = 2'b00;
        endcase
        return rw;
    endfunction

endpackage

// File: rtl/exe_mem_perf_cnt.sv
// exe_mem_perf_cnt
//   Free-running event counters for the EXE/MEM pipeline register.
//   Updates on the falling edge of clk, in step with the pipeline register.
// Ports:
//   clk, rst         falling-edge clock, asynchronous active-high reset
//   stall_in         stall request seen by the pipeline register
//   flush_in         flush request seen by the pipeline register
//   valid_in         EXE stage holds a real instruction
//   stall_cnt_out    edges held by stall (flush not asserted), wraps at 2^32
//   bubble_cnt_out   edges that loaded a bubble (flush or valid_in=0), wraps
module exe_mem_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        valid_in,
    output logic [31:0] stall_cnt_out,
    output logic [31:0] bubble_cnt_out
);

    logic stall_evt;
    logic bubble_evt;

    // Flush takes priority over stall, so a flushed edge is a bubble, not a stall.
    assign stall_evt  = stall_in & ~flush_in;
    assign bubble_evt = flush_in | (~stall_in & ~valid_in);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_out  <= '0;
            bubble_cnt_out <= '0;
        end else begin
            if (stall_evt)
                stall_cnt_out <= stall_cnt_out + 32'd1;
            if (bubble_evt)
                bubble_cnt_out <= bubble_cnt_out + 32'd1;
        end
    end

endmodule

// File: rtl/exe_mem_pipe.sv
// exe_mem_pipe
//   EXE -> MEM pipeline register. Captures the ALU result, store data,
//   destination index and decoded memory/writeback controls on the falling
//   edge of clk. Supports stall (hold), flush (bubble, wins over stall) and a
//   sticky flag for illegal memory-op encodings.
//   Optional feature: define EXE_MEM_PERF_CNT_EN to add stall/bubble counters
//   (stall_cnt_out, bubble_cnt_out) via exe_mem_perf_cnt.
// Ports:
//   clk, rst                    falling-edge clock, asynchronous active-high reset
//   stall_in, flush_in          hold / bubble-load requests
//   valid_in                    EXE holds a real instruction
//   controlmem_in[1:0]          00 none, 01 read, 10 write, 11 illegal
//   controlwb_in                writeback control
//   alu_in, wdata_in [DATA_W]   ALU result and store data
//   wreg_in [REG_W]             destination register index
//   valid_out, memread_out, memwrite_out, controlwb_out   registered controls
//   alu_out, wdata_out, wreg_out                          registered data
//   illegal_op_out              sticky illegal-op flag, cleared only by rst
module exe_mem_pipe
    import exe_mem_pipe_pkg::*;
#(
    parameter int               DATA_W  = 16,
    parameter int               REG_W   = 4,
    parameter logic [REG_W-1:0] NOP_REG = NOP_REG_DEF[REG_W-1:0],
    parameter logic             WB_IDLE = WB_IDLE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              valid_in,
    input  logic [1:0]        controlmem_in,
    input  logic              controlwb_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [REG_W-1:0]  wreg_in,
    output logic              valid_out,
    output logic              memread_out,
    output logic              memwrite_out,
    output logic              controlwb_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] wdata_out,
    output logic [REG_W-1:0]  wreg_out,
    output logic              illegal_op_out
`ifdef EXE_MEM_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt_out,
    output logic [31:0]       bubble_cnt_out
`endif
);

    logic              load_bubble;
    logic              load_instr;
    logic [1:0]        rw_dec;

    logic              vld_p1;
    logic              rd_p1;
    logic              wr_p1;
    logic              wb_p1;
    logic [DATA_W-1:0] alu_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic [REG_W-1:0]  wreg_p1;
    logic              ill_p1;

    // Flush wins over stall; an idle EXE slot also turns into a bubble.
    assign load_bubble = flush_in | (~stall_in & ~valid_in);
    assign load_instr  = ~flush_in & ~stall_in & valid_in;
    assign rw_dec      = decode_mem(controlmem_in);

    // ---- EXE -> MEM boundary (falling edge) ----
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            rd_p1    <= 1'b0;
            wr_p1    <= 1'b0;
            wb_p1    <= WB_IDLE;
            alu_p1   <= '0;
            wdata_p1 <= '0;
            wreg_p1  <= NOP_REG;
            ill_p1   <= 1'b0;
        end else if (load_bubble) begin
            vld_p1   <= 1'b0;
            rd_p1    <= 1'b0;
            wr_p1    <= 1'b0;
            wb_p1    <= WB_IDLE;
            alu_p1   <= '0;
            wdata_p1 <= '0;
            wreg_p1  <= NOP_REG;
        end else if (load_instr) begin
            vld_p1   <= 1'b1;
            rd_p1    <= rw_dec[1];
            wr_p1    <= rw_dec[0];
            wb_p1    <= controlwb_in;
            alu_p1   <= alu_in;
            wdata_p1 <= wdata_in;
            wreg_p1  <= wreg_in;
            // Sticky: only a reset clears it.
            if (controlmem_in == MEM_ILLEGAL)
                ill_p1 <= 1'b1;
        end
    end

    assign valid_out      = vld_p1;
    assign memread_out    = rd_p1;
    assign memwrite_out   = wr_p1;
    assign controlwb_out  = wb_p1;
    assign alu_out        = alu_p1;
    assign wdata_out      = wdata_p1;
    assign wreg_out       = wreg_p1;
    assign illegal_op_out = ill_p1;

`ifdef EXE_MEM_PERF_CNT_EN
    exe_mem_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .flush_in       (flush_in),
        .valid_in       (valid_in),
        .stall_cnt_out  (stall_cnt_out),
        .bubble_cnt_out (bubble_cnt_out)
    );
`else
    // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_exe_mem_pipe.sv
// tb_exe_mem_pipe
//   Scoreboard bench for exe_mem_pipe. Two instances share controls: one with
//   default parameters and one with DATA_W=32, REG_W=5. Stimulus pushes the
//   hand-computed expected outputs; a monitor pops and compares one entry
//   after every falling edge and after every reset assertion.
`timescale 1ns/1ps
module tb_exe_mem_pipe;

    typedef struct {
        logic        valid;
        logic        rd;
        logic        wr;
        logic        wb;
        logic [15:0] alu;
        logic [15:0] wdata;
        logic [3:0]  wreg;
        logic        ill;
        logic [31:0] alu32;
        logic [4:0]  wreg5;
        logic [31:0] scnt;
        logic [31:0] bcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        valid_in = 1'b0;
    logic [1:0]  controlmem_in = 2'b00;
    logic        controlwb_in = 1'b0;
    logic [15:0] alu_in = '0;
    logic [15:0] wdata_in = '0;
    logic [3:0]  wreg_in = '0;
    logic [31:0] alu32_in = '0;
    logic [31:0] wdata32_in;
    logic [4:0]  wreg5_in;

    logic        valid_a, rd_a, wr_a, wb_a, ill_a;
    logic [15:0] alu_a, wdata_a;
    logic [3:0]  wreg_a;
    logic        valid_b, rd_b, wr_b, wb_b, ill_b;
    logic [31:0] alu_b, wdata_b;
    logic [4:0]  wreg_b;
`ifdef EXE_MEM_PERF_CNT_EN
    logic [31:0] scnt_a, bcnt_a, scnt_b, bcnt_b;
`endif

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb[$];

    assign wdata32_in = {wdata_in, wdata_in};
    assign wreg5_in   = {1'b0, wreg_in};

    always #5 clk = ~clk;

    exe_mem_pipe dut_a (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .flush_in       (flush_in),
        .valid_in       (valid_in),
        .controlmem_in  (controlmem_in),
        .controlwb_in   (controlwb_in),
        .alu_in         (alu_in),
        .wdata_in       (wdata_in),
        .wreg_in        (wreg_in),
        .valid_out      (valid_a),
        .memread_out    (rd_a),
        .memwrite_out   (wr_a),
        .controlwb_out  (wb_a),
        .alu_out        (alu_a),
        .wdata_out      (wdata_a),
        .wreg_out       (wreg_a),
        .illegal_op_out (ill_a)
`ifdef EXE_MEM_PERF_CNT_EN
        ,
        .stall_cnt_out  (scnt_a),
        .bubble_cnt_out (bcnt_a)
`endif
    );

    exe_mem_pipe #(.DATA_W(32), .REG_W(5)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .flush_in       (flush_in),
        .valid_in       (valid_in),
        .controlmem_in  (controlmem_in),
        .controlwb_in   (controlwb_in),
        .alu_in         (alu32_in),
        .wdata_in       (wdata32_in),
        .wreg_in        (wreg5_in),
        .valid_out      (valid_b),
        .memread_out    (rd_b),
        .memwrite_out   (wr_b),
        .controlwb_out  (wb_b),
        .alu_out        (alu_b),
        .wdata_out      (wdata_b),
        .wreg_out       (wreg_b),
        .illegal_op_out (ill_b)
`ifdef EXE_MEM_PERF_CNT_EN
        ,
        .stall_cnt_out  (scnt_b),
        .bubble_cnt_out (bcnt_b)
`endif
    );

    function automatic exp_t mk(input logic v, input logic r, input logic w, input logic b,
                                input logic [15:0] a, input logic [15:0] d, input logic [3:0] g,
                                input logic i, input logic [31:0] a32, input logic [4:0] g5,
                                input logic [31:0] sc, input logic [31:0] bc);
        exp_t e;
        e.valid = v; e.rd = r; e.wr = w; e.wb = b;
        e.alu = a; e.wdata = d; e.wreg = g; e.ill = i;
        e.alu32 = a32; e.wreg5 = g5; e.scnt = sc; e.bcnt = bc;
        return e;
    endfunction

    function automatic exp_t bub(input logic i, input logic [31:0] sc, input logic [31:0] bc);
        return mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'hF, i,
                  32'h0, 5'h1F, sc, bc);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: compares one scoreboard entry per output event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("valid",     {63'd0, valid_a}, {63'd0, e.valid});
                check("memread",   {63'd0, rd_a},    {63'd0, e.rd});
                check("memwrite",  {63'd0, wr_a},    {63'd0, e.wr});
                check("rw_excl",   {63'd0, rd_a & wr_a}, 64'd0);
                check("wb",        {63'd0, wb_a},    {63'd0, e.wb});
                check("alu",       {48'd0, alu_a},   {48'd0, e.alu});
                check("wdata",     {48'd0, wdata_a}, {48'd0, e.wdata});
                check("wreg",      {60'd0, wreg_a},  {60'd0, e.wreg});
                check("illegal",   {63'd0, ill_a},   {63'd0, e.ill});
                check("b_valid",   {63'd0, valid_b}, {63'd0, e.valid});
                check("b_memread", {63'd0, rd_b},    {63'd0, e.rd});
                check("b_memwrite",{63'd0, wr_b},    {63'd0, e.wr});
                check("b_wb",      {63'd0, wb_b},    {63'd0, e.wb});
                check("b_alu",     {32'd0, alu_b},   {32'd0, e.alu32});
                check("b_wdata",   {32'd0, wdata_b}, {32'd0, e.wdata, e.wdata});
                check("b_wreg",    {59'd0, wreg_b},  {59'd0, e.wreg5});
                check("b_illegal", {63'd0, ill_b},   {63'd0, e.ill});
`ifdef EXE_MEM_PERF_CNT_EN
                check("stall_cnt",  {32'd0, scnt_a}, {32'd0, e.scnt});
                check("bubble_cnt", {32'd0, bcnt_a}, {32'd0, e.bcnt});
                check("b_stall_cnt",  {32'd0, scnt_b}, {32'd0, e.scnt});
                check("b_bubble_cnt", {32'd0, bcnt_b}, {32'd0, e.bcnt});
`endif
            end
        end
    end

    // Drive one cycle of inputs (called at posedge+1) and queue the response
    // expected after the following falling edge.
    task automatic step(input logic st, input logic fl, input logic vi, input logic [1:0] op,
                        input logic wb, input logic [15:0] a, input logic [15:0] d,
                        input logic [3:0] g, input logic [31:0] a32, input exp_t e);
        stall_in = st; flush_in = fl; valid_in = vi; controlmem_in = op;
        controlwb_in = wb; alu_in = a; wdata_in = d; wreg_in = g; alu32_in = a32;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t hold;
        // Reset asserted between edges: bubble appears without a clock edge.
        #2;
        sb.push_back(bub(1'b0, 32'd0, 32'd0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write load, 1-cycle latency.
        step(0, 0, 1, 2'b10, 0, 16'h1234, 16'hBEEF, 4'd3, 32'hDEADBEEF,
             mk(1, 0, 1, 0, 16'h1234, 16'hBEEF, 4'd3, 0, 32'hDEADBEEF, 5'h03, 0, 0));
        // Read load.
        hold = mk(1, 1, 0, 1, 16'h00AA, 16'h0055, 4'd5, 0, 32'h000000AA, 5'h05, 0, 0);
        step(0, 0, 1, 2'b01, 1, 16'h00AA, 16'h0055, 4'd5, 32'h000000AA, hold);
        // Stall three edges with different inputs: outputs hold.
        for (int k = 1; k <= 3; k++) begin
            hold.scnt = k;
            step(1, 0, 1, 2'b10, 0, 16'hFFFF, 16'h1111, 4'd7, 32'h12345678, hold);
        end
        // Stall and flush together: flush wins.
        step(1, 1, 1, 2'b10, 0, 16'hFFFF, 16'h1111, 4'd7, 32'h12345678, bub(0, 3, 1));
        // valid_in=0: bubble, other inputs ignored.
        step(0, 0, 0, 2'b01, 0, 16'h7777, 16'h8888, 4'd2, 32'h77777777, bub(0, 3, 2));
        // Illegal op: valid, no strobes, sticky flag set.
        step(0, 0, 1, 2'b11, 0, 16'h0BAD, 16'hC0DE, 4'd9, 32'hCAFEF00D,
             mk(1, 0, 0, 0, 16'h0BAD, 16'hC0DE, 4'd9, 1, 32'hCAFEF00D, 5'h09, 3, 2));
        // Op 00 afterwards: flag stays set.
        hold = mk(1, 0, 0, 1, 16'h0001, 16'h0002, 4'd1, 1, 32'h00000001, 5'h01, 3, 2);
        step(0, 0, 1, 2'b00, 1, 16'h0001, 16'h0002, 4'd1, 32'h00000001, hold);
        hold.scnt = 4;
        step(1, 0, 1, 2'b11, 0, 16'h5555, 16'h6666, 4'd6, 32'h55555555, hold);
        // Flush with an illegal op presented: not loaded, flag unchanged.
        step(0, 1, 1, 2'b11, 0, 16'h5555, 16'h6666, 4'd6, 32'h55555555, bub(1, 4, 3));

        // Reset asserted mid-stall: reset wins, flag and counters clear.
        stall_in = 1'b1; valid_in = 1'b1; controlmem_in = 2'b10; alu_in = 16'h9999;
        #1;
        sb.push_back(bub(0, 0, 0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        // First edge after release follows normal rules.
        step(0, 0, 1, 2'b01, 0, 16'h4321, 16'h0000, 4'd4, 32'h87654321,
             mk(1, 1, 0, 0, 16'h4321, 16'h0000, 4'd4, 0, 32'h87654321, 5'h04, 0, 0));
        // Illegal encoding with valid_in=0 must not set the flag.
        step(0, 0, 0, 2'b11, 0, 16'h1234, 16'h1234, 4'd8, 32'h11111111, bub(0, 0, 1));
        // All-ones data, destination equal to NOP_REG-1.
        step(0, 0, 1, 2'b10, 1, 16'hFFFF, 16'hABCD, 4'hE, 32'hFFFFFFFF,
             mk(1, 0, 1, 1, 16'hFFFF, 16'hABCD, 4'hE, 0, 32'hFFFFFFFF, 5'h0E, 0, 1));

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 20 && sb.size() > 0; k++)
            @(posedge clk);
        n_cmp++;
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
